lwe_decrypt_engine: RTL

- Datapath stage directly downstream of the operation controller.
- Consumes one ciphertext word and one secret-key word per cycle, at the addresses the controller sequences during OPCODE_DECRYPT.
- Computes the LWE plaintext m = round(t·(b − ⟨a,s⟩ mod q)/q) mod t and presents it to the result writeback.
- Both moduli are powers of two, so scaling reduces to a rounded right shift.

---
 rtl/lwe_pkg.sv | 25 ++
 rtl/lwe_round_scale.sv | 30 +++
 rtl/lwe_decrypt_engine.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lwe_pkg.sv
// Shared LWE package: opcode encodings (also decoded by the operation
// controller), default geometry, derived widths and the decrypt FSM
// state encoding.
package lwe_pkg;

  localparam logic [1:0] OPCODE_ENCRYPT = 2'b00;
  localparam logic [1:0] OPCODE_DECRYPT = 2'b01;
  localparam logic [1:0] OPCODE_ADD     = 2'b10;
  localparam logic [1:0] OPCODE_MULT    = 2'b11;

  // Default geometry: t = 64, q = 1024, n = 10.
  localparam int LWE_PW  = 6;
  localparam int LWE_CW  = 10;
  localparam int LWE_DIM = 10;

  localparam int SCALE_SHIFT = LWE_CW - LWE_PW;
  localparam int IDX_WIDTH   = $clog2(LWE_DIM + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } lwe_state_e;

endpackage

// File: rtl/lwe_round_scale.sv
// Combinational LWE rescale: d = (b - acc) mod q, then
// result = ((d + 2^(S-1)) >> S) mod t with S = CW - PW.
// Ports:
//   i_b      [CW-1:0]  ciphertext body b
//   i_acc    [CW-1:0]  inner product <a,s> mod q
//   o_result [PW-1:0]  rounded plaintext
module lwe_round_scale #(
  parameter int CW = 10,
  parameter int PW = 6
) (
  input  logic [CW-1:0] i_b,
  input  logic [CW-1:0] i_acc,
  output logic [PW-1:0] o_result
);

  localparam int S = CW - PW;

  logic [CW-1:0] w_diff;
  logic [CW:0]   w_sum;

  // Natural CW-bit wrap gives the mod-q subtraction for free.
  assign w_diff = i_b - i_acc;

  // One extra bit so d near q does not lose the carry before the shift;
  // the carry lands at bit PW of the shifted value and is dropped, which
  // is the final mod t.
  assign w_sum    = {1'b0, w_diff} + ((CW+1)'(1) << (S - 1));
  assign o_result = PW'(w_sum >> S);

endmodule

// File: rtl/lwe_decrypt_engine.sv
// LWE decrypt datapath. Consumes (a_i, s_i) pairs for words 0..n-1 and b on
// word n, and produces m = round(t*(b - <a,s>)/q) mod t.
// Two-stage pipeline: stage 1 registers a_i*s_i mod q (or b, tagged),
// stage 2 accumulates and, on the b tag, rescales into result.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                pulse: begin new decryption (aborts any in progress)
//   in_valid             ct_word/sk_word valid this cycle
//   ct_word, sk_word     ciphertext word / secret key word
//   busy                 high from the cycle after start until out_valid
//   out_valid            one-cycle pulse: result is new
//   result               plaintext, held until overwritten or reset
//   word_idx             index of the next word to be accepted
module lwe_decrypt_engine
  import lwe_pkg::*;
#(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = LWE_PW,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = LWE_CW,
  parameter int DIMENSION          = LWE_DIM,
  localparam int IW = $clog2(DIMENSION + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic [CIPHERTEXT_WIDTH-1:0] ct_word,
  input  logic [CIPHERTEXT_WIDTH-1:0] sk_word,
  output logic                        busy,
  output logic                        out_valid,
  output logic [PLAINTEXT_WIDTH-1:0]  result,
  output logic [IW-1:0]               word_idx
);

  localparam int CW = CIPHERTEXT_WIDTH;
  localparam int PW = PLAINTEXT_WIDTH;

  // Both moduli must be powers of two matching their widths, and q > t,
  // otherwise the rounded shift is not the correct rescale.
  if (PLAINTEXT_MODULUS != (1 << PW)) begin : g_bad_t
    $error("PLAINTEXT_MODULUS must equal 2**PLAINTEXT_WIDTH");
  end
  if (CIPHERTEXT_MODULUS != (1 << CW)) begin : g_bad_q
    $error("CIPHERTEXT_MODULUS must equal 2**CIPHERTEXT_WIDTH");
  end
  if (CW <= PW) begin : g_bad_qt
    $error("CIPHERTEXT_WIDTH must exceed PLAINTEXT_WIDTH");
  end

  lwe_state_e    r_state, w_state_nxt;
  logic          w_accept;
  logic          w_last;
  logic [CW-1:0] w_prod;
  logic [PW-1:0] w_res;

  logic          r_s1_vld;
  logic          r_s1_is_b;
  logic [CW-1:0] r_s1_data;
  logic [CW-1:0] r_acc;
  logic          r_out_valid;
  logic [PW-1:0] r_result;
  logic [IW-1:0] r_word_idx;

  assign w_last = (r_word_idx == IW'(DIMENSION));
  // Assigning into a CW-bit net keeps only the low CW bits: mod q.
  assign w_prod = ct_word * sk_word;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    if (start) begin
      // start wins in every state; a word offered with it is dropped.
      w_state_nxt = ACCUM;
    end else begin
      case (r_state)
        IDLE:  w_state_nxt = IDLE;
        ACCUM: begin
          if (in_valid) begin
            w_accept = 1'b1;
            if (w_last) w_state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          // b is in stage 1; stage 2 consumes it on this edge.
          if (r_s1_vld && r_s1_is_b) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld    <= 1'b0;
      r_s1_is_b   <= 1'b0;
      r_s1_data   <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_word_idx  <= '0;
    end else if (start) begin
      r_s1_vld    <= 1'b0;
      r_s1_is_b   <= 1'b0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_word_idx  <= '0;
    end else begin
      // stage 1
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_word_idx <= r_word_idx + 1'b1;
        r_s1_is_b  <= w_last;
        r_s1_data  <= w_last ? ct_word : w_prod;
      end
      // stage 2
      r_out_valid <= r_s1_vld && r_s1_is_b;
      if (r_s1_vld) begin
        if (r_s1_is_b) r_result <= w_res;
        else           r_acc    <= r_acc + r_s1_data;
      end
    end
  end

  lwe_round_scale #(
    .CW(CW),
    .PW(PW)
  ) u_round_scale (
    .i_b      (r_s1_data),
    .i_acc    (r_acc),
    .o_result (w_res)
  );

  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign word_idx  = r_word_idx;

endmodule
